// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the Wishbone master arbiter.
// No logic; latency and backpressure are defined by the users of this package.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

  localparam int NM_DEF  = 3;
  localparam int AW_DEF  = 32;
  localparam int DW_DEF  = 32;
  localparam int TMO_DEF = 1023;

  // Timeout counter width; kept at least 1 bit so a disabled timeout still elaborates.
  function automatic int tmo_w(input int tmo);
    return (tmo < 1) ? 1 : $clog2(tmo + 1);
  endfunction

endpackage

// File: rtl/wb_arb_rr.sv
// Combinational round-robin picker: first requester after last_i, wrapping.
// Zero latency; no backpressure, the caller decides when to take the result.
module wb_arb_rr #(
  parameter int NM = 3,
  parameter int IW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] req_i,
  input  logic [IW-1:0] last_i,
  output logic [NM-1:0] gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = 1; k <= NM; k++) begin
      if (!vld_o && req_i[(int'(last_i) + k) % NM]) begin
        vld_o                              = 1'b1;
        idx_o                              = IW'((int'(last_i) + k) % NM);
        gnt_o[(int'(last_i) + k) % NM]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_master_arb.sv
// Round-robin Wishbone arbiter: one owner per cyc tenure, stalled strobes aborted with err.
// Grant 1 cycle after request, ack/err pass through combinationally; slave stalls are bounded by TMO_CYC.
module wb_master_arb
  import wb_arb_pkg::*;
#(
  parameter int NM      = NM_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TMO_CYC = TMO_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic [NM-1:0]     m_cyc_i,
  input  logic [NM-1:0]     m_stb_i,
  input  logic [NM-1:0]     m_we_i,
  input  logic [4*NM-1:0]   m_sel_i,
  input  logic [AW*NM-1:0]  m_adr_i,
  input  logic [DW*NM-1:0]  m_dat_i,
  output logic [DW-1:0]     m_dat_o,
  output logic [NM-1:0]     m_ack_o,
  output logic [NM-1:0]     m_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [3:0]        s_sel_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  output logic [NM-1:0]     gnt_o,
  output logic              tmo_o
);

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW = tmo_w(TMO_CYC);

  arb_state_e    state_q;
  logic [NM-1:0] gnt_q;
  logic [IW-1:0] own_q;   // current owner while granted, last owner otherwise
  logic [CW-1:0] cnt_q, cnt_d;

  logic [NM-1:0] rr_gnt;
  logic [IW-1:0] rr_idx;
  logic          rr_vld;
  logic          in_grant, own_cyc, rsp, tmo_hit;

  wb_arb_rr #(.NM(NM), .IW(IW)) u_rr (
    .req_i  (m_cyc_i),
    .last_i (own_q),
    .gnt_o  (rr_gnt),
    .idx_o  (rr_idx),
    .vld_o  (rr_vld)
  );

  assign in_grant = (state_q == GRANT);
  assign own_cyc  = m_cyc_i[own_q];
  assign rsp      = s_ack_i | s_err_i;

  assign s_cyc_o = in_grant & own_cyc;
  assign s_stb_o = in_grant & own_cyc & m_stb_i[own_q];
  assign s_we_o  = in_grant & m_we_i[own_q];
  assign s_sel_o = in_grant ? m_sel_i[int'(own_q)*4 +: 4]   : '0;
  assign s_adr_o = in_grant ? m_adr_i[int'(own_q)*AW +: AW] : '0;
  assign s_dat_o = in_grant ? m_dat_i[int'(own_q)*DW +: DW] : '0;

  // Responses outside GRANT are late slave replies and go nowhere.
  assign m_dat_o = s_dat_i;
  assign m_ack_o = in_grant ? (gnt_q & {NM{s_ack_i}}) : '0;
  assign m_err_o = in_grant              ? (gnt_q & {NM{s_err_i}}) :
                   (state_q == ABORT)    ? gnt_q : '0;
  assign tmo_o   = (state_q == ABORT);
  assign gnt_o   = gnt_q;

  assign tmo_hit = (TMO_CYC != 0) && s_stb_o && !rsp && (cnt_q == CW'(TMO_CYC));

  always_comb begin
    cnt_d = '0;
    if (s_stb_o && !rsp)
      cnt_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      own_q   <= IW'(NM - 1);
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      unique case (state_q)
        IDLE: begin
          if (rr_vld) begin
            state_q <= GRANT;
            gnt_q   <= rr_gnt;
            own_q   <= rr_idx;
          end
        end
        GRANT: begin
          if (!own_cyc) begin
            state_q <= IDLE;
            gnt_q   <= '0;
          end else if (tmo_hit) begin
            state_q <= ABORT;
          end
        end
        ABORT: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_arb.sv
// Directed bench for wb_master_arb with three masters and an 8-cycle timeout.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
module tb_wb_master_arb;

  localparam int NM  = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic              clk, rst_n;
  logic [NM-1:0]     m_cyc, m_stb, m_we;
  logic [4*NM-1:0]   m_sel;
  logic [AW*NM-1:0]  m_adr;
  logic [DW*NM-1:0]  m_dat;
  logic [DW-1:0]     m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o, gnt_o;
  logic              s_cyc_o, s_stb_o, s_we_o, tmo_o;
  logic [3:0]        s_sel_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [DW-1:0]     s_dat;
  logic              s_ack, s_err;

  logic [31:0]       adr_tab [NM];
  int                n_chk  = 0;
  int                n_fail = 0;

  wb_master_arb #(.NM(NM), .AW(AW), .DW(DW), .TMO_CYC(TMO)) dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .m_cyc_i  (m_cyc),
    .m_stb_i  (m_stb),
    .m_we_i   (m_we),
    .m_sel_i  (m_sel),
    .m_adr_i  (m_adr),
    .m_dat_i  (m_dat),
    .m_dat_o  (m_dat_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_sel_o  (s_sel_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_dat_i  (s_dat),
    .s_ack_i  (s_ack),
    .s_err_i  (s_err),
    .gnt_o    (gnt_o),
    .tmo_o    (tmo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic req(input int i, input logic we, input logic [3:0] sel,
                     input logic [31:0] adr, input logic [31:0] dat);
    m_cyc[i]          = 1'b1;
    m_stb[i]          = 1'b1;
    m_we[i]           = we;
    m_sel[i*4 +: 4]   = sel;
    m_adr[i*AW +: AW] = adr;
    m_dat[i*DW +: DW] = dat;
  endtask

  task automatic drop(input int i);
    m_cyc[i] = 1'b0;
    m_stb[i] = 1'b0;
  endtask

  // Owner i is granted now: ack one strobe, release, check the bubble, step to next grant.
  task automatic serve(input int i, input logic [2:0] exp, input string tag);
    chk({tag, "_gnt"}, gnt_o, exp);
    chk({tag, "_adr"}, s_adr_o, adr_tab[i]);
    s_ack = 1'b1;
    settle();
    chk({tag, "_ack"}, m_ack_o, exp);
    tick();
    s_ack = 1'b0;
    drop(i);
    tick();
    chk({tag, "_bubble"}, gnt_o, 0);
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    adr_tab[0] = 32'h1000_0000;
    adr_tab[1] = 32'h2000_0004;
    adr_tab[2] = 32'h3000_0008;
    rst_n = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_sel = '0; m_adr = '0; m_dat = '0;
    s_dat = '0; s_ack = 1'b0; s_err = 1'b0;
    #12;
    chk("rst_gnt",  gnt_o,   0);
    chk("rst_scyc", s_cyc_o, 0);
    chk("rst_sstb", s_stb_o, 0);
    chk("rst_ack",  m_ack_o, 0);
    chk("rst_err",  m_err_o, 0);
    chk("rst_tmo",  tmo_o,   0);
    rst_n = 1'b1;
    tick();

    // Contention: all three at once, two rounds
    for (int i = 0; i < NM; i++) req(i, 1'b0, 4'hF, adr_tab[i], 32'h0);
    settle();
    chk("rr_pre_gnt", gnt_o, 0);
    tick();
    serve(0, 3'b001, "rr0");
    serve(1, 3'b010, "rr1");
    serve(2, 3'b100, "rr2");
    for (int i = 0; i < NM; i++) req(i, 1'b0, 4'hF, adr_tab[i], 32'h0);
    tick();
    serve(0, 3'b001, "rr2_0");
    serve(1, 3'b010, "rr2_1");
    serve(2, 3'b100, "rr2_2");

    // Single master write from M1
    req(1, 1'b1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF);
    settle();
    chk("sm_pre_gnt", gnt_o, 0);
    tick();
    chk("sm_gnt",  gnt_o,   3'b010);
    chk("sm_scyc", s_cyc_o, 1);
    chk("sm_sstb", s_stb_o, 1);
    chk("sm_swe",  s_we_o,  1);
    chk("sm_sadr", s_adr_o, 32'h3000_0010);
    chk("sm_sdat", s_dat_o, 32'hDEAD_BEEF);
    chk("sm_ssel", s_sel_o, 4'hF);
    chk("sm_noack", m_ack_o, 0);
    s_ack = 1'b1;
    settle();
    chk("sm_ack", m_ack_o, 3'b010);
    tick();
    s_ack = 1'b0;
    drop(1);
    settle();
    chk("sm_cyc_fall", s_cyc_o, 0);
    tick();
    chk("sm_idle", gnt_o, 0);

    // Lock: M2 bursts 4 strobes while M0 waits
    req(2, 1'b0, 4'h3, adr_tab[2], 32'h0);
    tick();
    chk("lk_gnt", gnt_o, 3'b100);
    req(0, 1'b0, 4'hF, adr_tab[0], 32'h0);
    for (int k = 0; k < 4; k++) begin
      s_ack = 1'b1;
      settle();
      chk($sformatf("lk_hold%0d", k), gnt_o, 3'b100);
      chk($sformatf("lk_ack%0d", k), m_ack_o, 3'b100);
      tick();
    end
    s_ack = 1'b0;
    drop(2);
    settle();
    chk("lk_still", gnt_o, 3'b100);
    tick();
    chk("lk_bubble", gnt_o, 0);
    tick();
    chk("lk_m0", gnt_o, 3'b001);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    drop(0);
    tick();
    tick();

    // Slave error on M1 read
    req(1, 1'b0, 4'hF, 32'h4000_0020, 32'h0);
    tick();
    chk("er_gnt", gnt_o, 3'b010);
    s_err = 1'b1;
    s_dat = 32'hCAFE_F00D;
    settle();
    chk("er_err", m_err_o, 3'b010);
    chk("er_ack", m_ack_o, 0);
    chk("er_dat", m_dat_o, 32'hCAFE_F00D);
    tick();
    s_err = 1'b0;
    settle();
    chk("er_keep", gnt_o, 3'b010);
    chk("er_clr", m_err_o, 0);
    drop(1);
    s_dat = '0;
    tick();
    tick();

    // Timeout: M0 strobes, slave silent
    req(0, 1'b0, 4'hF, 32'h5000_0000, 32'h0);
    tick();
    chk("to_gnt", gnt_o, 3'b001);
    chk("to_stb", s_stb_o, 1);
    for (int k = 1; k <= TMO; k++) begin
      tick();
      chk($sformatf("to_wait%0d", k), {tmo_o, m_err_o}, 0);
    end
    tick();
    chk("to_err",  m_err_o, 3'b001);
    chk("to_tmo",  tmo_o,   1);
    chk("to_scyc", s_cyc_o, 0);
    drop(0);
    tick();
    chk("to_idle", gnt_o, 0);
    chk("to_tmo_off", tmo_o, 0);
    s_ack = 1'b1;
    settle();
    chk("to_late_ack", m_ack_o, 0);
    s_ack = 1'b0;

    // Reset mid-access
    req(0, 1'b0, 4'hF, 32'h6000_0000, 32'h0);
    tick();
    chk("rm_scyc", s_cyc_o, 1);
    s_ack = 1'b1;
    settle();
    chk("rm_ack_pre", m_ack_o, 3'b001);
    rst_n = 1'b0;
    settle();
    chk("rm_scyc0", s_cyc_o, 0);
    chk("rm_sstb0", s_stb_o, 0);
    chk("rm_gnt0",  gnt_o,   0);
    chk("rm_ack0",  m_ack_o, 0);
    chk("rm_err0",  m_err_o, 0);
    chk("rm_tmo0",  tmo_o,   0);
    chk("rm_dat0",  m_dat_o, 0);
    s_ack = 1'b0;
    for (int i = 0; i < NM; i++) req(i, 1'b0, 4'hF, adr_tab[i], 32'h0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("rm_first", gnt_o, 3'b001);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_master_arb.md
# wb_master_arb

Round-robin Wishbone arbiter that shares the single internal Wishbone slave path of `digital_core` between several bus masters: management-SoC external port, RISC-V data port and UART debug master. It sits between those masters and the core's Wishbone interconnect. It grants one master at a time and holds the grant for the whole `cyc` tenure. It aborts any stalled access with an error after a programmable timeout.

## Interface
- `NM`, 3: number of masters (2..8)
- `AW`, 32: address width
- `DW`, 32: data width
- `TMO_CYC`, 1023: max cycles a strobed access may wait for ack/err; 0 disables the timeout
- `wb_clk_i`  in  1  bus clock; all state on rising edge
- `wb_rst_n`  in  1  reset, asynchronous, active-low
- `m_cyc_i`  in  NM  per-master cycle
- `m_stb_i`  in  NM  per-master strobe
- `m_we_i`  in  NM  per-master write enable
- `m_sel_i`  in  4*NM  byte selects, master i at [4i+3:4i]
- `m_adr_i`  in  AW*NM  addresses, packed the same way
- `m_dat_i`  in  DW*NM  write data, packed the same way
- `m_dat_o`  out  DW  read data, broadcast to all masters
- `m_ack_o`  out  NM  per-master ack
- `m_err_o`  out  NM  per-master error
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  to slave
- `s_sel_o`  out  4  to slave
- `s_adr_o`  out  AW  to slave
- `s_dat_o`  out  DW  to slave
- `s_dat_i`  in  DW  read data from slave
- `s_ack_i`  in  1  ack from slave
- `s_err_i`  in  1  error from slave
- `gnt_o`  out  NM  one-hot current owner; 0 when idle
- `tmo_o`  out  1  one-cycle pulse on timeout abort

## Operation
- States: IDLE, GRANT, ABORT.
- IDLE
  - All `s_*` control outputs are 0.
  - If any `m_cyc_i` is high: choose the owner by round-robin and go to GRANT.
- Round-robin search starts at (last_owner+1) mod NM. Reset value of last_owner is NM-1, so master 0 wins first.
- GRANT
  - `s_*` outputs mux the owner's signals.
  - `m_ack_o[owner]` = `s_ack_i`, `m_err_o[owner]` = `s_err_i`; all other masters see 0.
  - `m_dat_o` = `s_dat_i` unconditionally.
  - The grant is held across multiple ack'd strobes while the owner keeps `cyc` high (lock/burst).
  - When `m_cyc_i[owner]` is low: go to IDLE.
- Timeout counter
  - Clears on every `s_ack_i`/`s_err_i`, and whenever `s_stb_o` is low.
  - Increments while `s_stb_o` is high with no ack/err.
  - When it reaches `TMO_CYC`: go to ABORT.
- ABORT, exactly one cycle
  - `s_cyc_o`/`s_stb_o` = 0.
  - `m_err_o[owner]` = 1, `tmo_o` = 1.
  - Then go to IDLE.
- An owner that drops `cyc` mid-strobe is legal. The slave sees `cyc` fall and the grant releases.
- A late `s_ack_i` arriving in IDLE or ABORT is discarded and routed to no master.
- Reset values: state IDLE, `gnt_o` 0, all `s_*` 0, `m_ack_o`/`m_err_o` 0, `tmo_o` 0, counter 0.
- Reset asserted mid-access drops `s_cyc_o` asynchronously.

## Timing
- Grant latency: request at cycle N → `gnt_o` and `s_cyc_o`/`s_stb_o` registered high at N+1.
- Return path `s_ack_i`/`s_err_i` → `m_ack_o`/`m_err_o` is combinational, zero cycles.
- Release: owner `cyc` low at cycle N → IDLE at N+1 → next grant at N+2. One bubble cycle per handover, always.
- Simultaneous requests: the round-robin order decides. A master requesting in the release cycle is considered at N+1.
- Timeout fires when the counter equals `TMO_CYC`: `m_err_o` is seen `TMO_CYC`+1 cycles after `stb` was first presented.
- Counter width is clog2(`TMO_CYC`+1) and it saturates; it never wraps.

## Structure
- Package `wb_arb_pkg`:
  - state enum {IDLE, GRANT, ABORT}
  - `TMO_W` function (clog2)
  - default parameter constants
- Sub-module `wb_arb_rr`: combinational round-robin picker. Inputs: NM request vector and last owner index. Outputs: one-hot grant and index.
- The top holds the FSM, grant register, timeout counter and muxes.

## Test plan
- **Single master:** M1 writes 0xDEADBEEF to 0x3000_0010 with sel 0xF.
  - `gnt_o`=3'b010 one cycle after `cyc`; slave sees the exact adr/dat/sel.
  - `m_ack_o`=3'b010 in the same cycle as `s_ack_i`.
- **Contention:** M0, M1, M2 all request in the same cycle, each one strobe.
  - Grants go M0 → M1 → M2, with one idle cycle between tenures.
  - A second round from reset state last_owner=2 starts again at M0.
- **Lock:** M2 holds `cyc` for 4 strobes while M0 requests.
  - `gnt_o` stays 3'b100 through all 4 acks.
  - M0 is granted 2 cycles after M2 drops `cyc`.
- **Timeout:** `TMO_CYC`=8, M0 strobes and the slave never acks.
  - `m_err_o`[0] and `tmo_o` high exactly 9 cycles after the strobe, `s_cyc_o` low that cycle, then IDLE.
  - A late `s_ack_i` in a later idle cycle produces no `m_ack_o`.
- **Slave error:** `s_err_i` pulses for M1's read.
  - `m_err_o`=3'b010 combinationally; `m_ack_o` stays 0; the grant is retained.
- **Reset mid-access:** `wb_rst_n` low while M0 is strobed.
  - All outputs are 0 immediately, without a clock.
  - After release, the first grant goes to M0.
